// File: rtl/io_port_responder.sv
// io_port_responder
//   Port-mapped I/O responder for a small CPU's OUT/IN bus. OUT writes
//   (io_strb high) update the peripheral registers. IN reads are answered
//   combinationally on in_port from port_id.
//   The block contains:
//     - an LED latch
//     - two-flop synchronisers for the switches and buttons
//     - a 16-bit down-counting timer
//     - a two-source maskable interrupt controller
//       (bit0 = timer expiry, bit1 = any button rising edge)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   port_id    I/O address from the CPU
//   out_port   OUT write data
//   io_strb    one-cycle OUT write strobe
//   in_port    IN read data, combinational from port_id
//   sw_in      raw asynchronous switches
//   btn_in     raw asynchronous buttons, active high
//   led_out    registered LED latch
//   interrupt  level interrupt = |(pending & mask)
module io_port_responder #(
  parameter int N_BTN = 4,
  parameter int TMR_W = 16   // LO/HI byte map assumes 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       port_id,
  input  logic [7:0]       out_port,
  input  logic             io_strb,
  output logic [7:0]       in_port,
  input  logic [7:0]       sw_in,
  input  logic [N_BTN-1:0] btn_in,
  output logic [7:0]       led_out,
  output logic             interrupt
);

  localparam logic [7:0] WR_LED  = 8'h40;
  localparam logic [7:0] WR_TLO  = 8'h41;
  localparam logic [7:0] WR_THI  = 8'h42;
  localparam logic [7:0] WR_CTRL = 8'h43;
  localparam logic [7:0] WR_ACK  = 8'h44;
  localparam logic [7:0] WR_MASK = 8'h45;

  logic [7:0]       led_q, led_d;
  logic [TMR_W-1:0] reload_q, reload_d;
  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             auto_q, auto_d;
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       mask_q, mask_d;
  logic [7:0]       sw_s1_q, sw_s2_q;
  logic [N_BTN-1:0] btn_s1_q, btn_s2_q, btn_prev_q;

  logic tmr_expire;
  logic btn_edge;
  logic [7:0] btn_byte;

  // Expiry depends only on the current state. A simultaneous CTRL write
  // overrides the counter update, but the expiry still raises pending.
  assign tmr_expire = en_q && (cnt_q == '0);
  assign btn_edge   = |(btn_s2_q & ~btn_prev_q);

  always_comb begin
    led_d    = led_q;
    reload_d = reload_q;
    cnt_d    = cnt_q;
    en_d     = en_q;
    auto_d   = auto_q;
    mask_d   = mask_q;
    pend_d   = pend_q;

    if (io_strb && port_id == WR_LED)  led_d          = out_port;
    if (io_strb && port_id == WR_TLO)  reload_d[7:0]  = out_port;
    if (io_strb && port_id == WR_THI)  reload_d[15:8] = out_port;
    if (io_strb && port_id == WR_MASK) mask_d         = out_port[1:0];

    if (io_strb && port_id == WR_CTRL) begin
      en_d   = out_port[0];
      auto_d = out_port[1];
      if (out_port[0]) cnt_d = reload_q;
    end else if (en_q) begin
      if (cnt_q != '0)  cnt_d = cnt_q - TMR_W'(1);
      else if (auto_q)  cnt_d = reload_q;
      else              en_d  = 1'b0;
    end

    // The acknowledge clear is applied first, so a set on the same edge wins.
    if (io_strb && port_id == WR_ACK) pend_d = pend_q & ~out_port[1:0];
    pend_d = pend_d | {btn_edge, tmr_expire};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q      <= '0;
      reload_q   <= '0;
      cnt_q      <= '0;
      en_q       <= 1'b0;
      auto_q     <= 1'b0;
      pend_q     <= '0;
      mask_q     <= '0;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      btn_prev_q <= '0;
    end else begin
      led_q      <= led_d;
      reload_q   <= reload_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      auto_q     <= auto_d;
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      sw_s1_q    <= sw_in;
      sw_s2_q    <= sw_s1_q;
      btn_s1_q   <= btn_in;
      btn_s2_q   <= btn_s1_q;
      btn_prev_q <= btn_s2_q;
    end
  end

  always_comb begin
    btn_byte              = '0;
    btn_byte[N_BTN-1:0]   = btn_s2_q;
  end

  always_comb begin
    in_port = 8'h00;
    case (port_id)
      8'h20:   in_port = sw_s2_q;
      8'h21:   in_port = btn_byte;
      8'h22:   in_port = {6'b0, pend_q};
      8'h23:   in_port = cnt_q[7:0];
      8'h24:   in_port = cnt_q[15:8];
      8'h25:   in_port = {6'b0, mask_q};
      8'h26:   in_port = {6'b0, auto_q, en_q};
      default: in_port = 8'h00;
    endcase
  end

  assign led_out   = led_q;
  assign interrupt = |(pend_q & mask_q);

endmodule

// File: tb/tb_io_port_responder.sv
// tb_io_port_responder
//   Directed checks for io_port_responder. The expected values are worked
//   out cycle by cycle in the comments next to each check.
module tb_io_port_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] port_id, out_port, in_port, sw_in, led_out;
  logic       io_strb, interrupt;
  logic [3:0] btn_in;
  logic [7:0] rv;

  int n_cmp = 0;
  int n_err = 0;

  io_port_responder #(.N_BTN(4), .TMR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .port_id(port_id), .out_port(out_port),
    .io_strb(io_strb), .in_port(in_port), .sw_in(sw_in), .btn_in(btn_in),
    .led_out(led_out), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [7:0] id, input logic [7:0] d);
    port_id  = id;
    out_port = d;
    io_strb  = 1'b1;
    tick();
    io_strb  = 1'b0;
    out_port = 8'h00;
    $display("OUT  port 0x%02h <= 0x%02h", id, d);
  endtask

  task automatic check_rd(input string tag, input logic [7:0] id, input logic [7:0] exp);
    port_id = id;
    #1;
    rv = in_port;
    $display("IN   port 0x%02h -> 0x%02h", id, rv);
    check_val(tag, {8'h00, rv}, {8'h00, exp});
  endtask

  initial begin
    rst_n = 1'b0; port_id = 8'h00; out_port = 8'h00; io_strb = 1'b0;
    sw_in = 8'h00; btn_in = 4'h0;
    tick(); tick();
    check_val("rst_led", {8'h0, led_out}, 16'h0);
    check_val("rst_irq", {15'h0, interrupt}, 16'h0);
    check_rd("rst_pend", 8'h22, 8'h00);
    check_rd("rst_ctrl", 8'h26, 8'h00);
    rst_n = 1'b1;
    tick();

    // LED latch: strobed write, unstrobed write, unmapped write
    io_write(8'h40, 8'hA5);
    check_val("led_wr", {8'h0, led_out}, 16'h00A5);
    port_id = 8'h40; out_port = 8'h11; io_strb = 1'b0;
    tick();
    check_val("led_nostrb", {8'h0, led_out}, 16'h00A5);
    io_write(8'h4F, 8'h22);
    check_val("led_unmapped", {8'h0, led_out}, 16'h00A5);

    // Auto-reload timer, reload 3: expiry 4 edges after the CTRL edge
    io_write(8'h41, 8'h03);
    io_write(8'h42, 8'h00);
    io_write(8'h45, 8'h01);
    check_rd("mask_rd", 8'h25, 8'h01);
    io_write(8'h43, 8'h03);                       // E0: cnt=3
    check_rd("tmr_load", 8'h23, 8'h03);
    check_rd("ctrl_rd", 8'h26, 8'h03);
    tick(); tick(); tick();                       // E3: cnt=0
    check_val("irq_e3", {15'h0, interrupt}, 16'h0);
    check_rd("cnt_e3", 8'h23, 8'h00);
    tick();                                       // E4: expiry
    check_val("irq_e4", {15'h0, interrupt}, 16'h1);
    check_rd("cnt_reload", 8'h23, 8'h03);
    io_write(8'h44, 8'h01);                       // E5: ack, cnt=2
    check_val("irq_ack", {15'h0, interrupt}, 16'h0);
    tick(); tick();                               // E7: cnt=0
    check_val("irq_e7", {15'h0, interrupt}, 16'h0);
    tick();                                       // E8: second expiry
    check_val("irq_e8", {15'h0, interrupt}, 16'h1);

    // One-shot timer
    io_write(8'h44, 8'h01);                       // E9: cnt=2, pend clear
    io_write(8'h43, 8'h01);                       // E10: cnt=3, auto=0
    tick(); tick(); tick();
    check_val("oneshot_pre", {15'h0, interrupt}, 16'h0);
    tick();                                       // E14: expiry, en->0
    check_val("oneshot_irq", {15'h0, interrupt}, 16'h1);
    check_rd("oneshot_ctrl", 8'h26, 8'h00);
    io_write(8'h44, 8'h01);
    for (int i = 0; i < 5; i++) tick();
    check_val("oneshot_quiet", {15'h0, interrupt}, 16'h0);
    check_rd("oneshot_cnt", 8'h23, 8'h00);

    // Ack on the same edge as an expiry: set wins
    io_write(8'h41, 8'h02);
    io_write(8'h43, 8'h03);                       // F0: cnt=2
    tick(); tick();                               // F2: cnt=0
    io_write(8'h44, 8'h01);                       // F3: expiry + ack
    check_rd("ack_vs_set", 8'h22, 8'h01);
    io_write(8'h44, 8'h01);                       // F4: cnt=1, pend clear
    check_rd("ack_clear", 8'h22, 8'h00);
    tick();                                       // F5: cnt=0
    io_write(8'h43, 8'h03);                       // F6: CTRL write + expiry
    check_rd("ctrl_vs_exp_cnt", 8'h23, 8'h02);
    check_rd("ctrl_vs_exp_pend", 8'h22, 8'h01);
    io_write(8'h43, 8'h00);                       // F7: disable, cnt holds 2
    io_write(8'h44, 8'h01);
    tick(); tick();
    check_rd("tmr_hold", 8'h23, 8'h02);

    // Button edge with masking
    io_write(8'h45, 8'h00);
    btn_in = 4'b0100;                             // rises after G0
    tick(); tick();                               // G2
    check_rd("btn_g2", 8'h22, 8'h00);
    tick();                                       // G3
    check_rd("btn_g3", 8'h22, 8'h02);
    check_val("btn_masked", {15'h0, interrupt}, 16'h0);
    check_rd("btn_rd", 8'h21, 8'h04);
    io_write(8'h45, 8'h02);
    check_val("btn_unmasked", {15'h0, interrupt}, 16'h1);
    io_write(8'h44, 8'h02);
    tick(); tick();
    check_val("btn_acked", {15'h0, interrupt}, 16'h0);

    // Switch synchroniser and unmapped read
    sw_in = 8'h3C;                                // after H0
    port_id = 8'h20;
    tick();
    check_rd("sw_h1", 8'h20, 8'h00);
    tick();
    check_rd("sw_h2", 8'h20, 8'h3C);
    check_rd("rd_unmapped", 8'h7F, 8'h00);

    // Reset in mid-count with pending set
    io_write(8'h45, 8'h01);
    io_write(8'h41, 8'h03);
    io_write(8'h43, 8'h03);
    for (int i = 0; i < 5; i++) tick();           // expiry has occurred
    check_val("pre_rst_irq", {15'h0, interrupt}, 16'h1);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_led", {8'h0, led_out}, 16'h0);
    check_val("mid_rst_irq", {15'h0, interrupt}, 16'h0);
    check_rd("mid_rst_pend", 8'h22, 8'h00);
    check_rd("mid_rst_cnt", 8'h23, 8'h00);
    check_rd("mid_rst_sw", 8'h20, 8'h00);
    tick();
    check_rd("mid_rst_mask", 8'h25, 8'h00);
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
